// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-way mux-path round-robin arbiter.
//   NUM_REQ / SEL_W : requester count and select width
//   arb_state_t     : sequencer states
//   onehot_to_idx   : 4-bit one-hot to 2-bit index (zero input gives 0)
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker.
//   req   [3:0] : request vector
//   last  [1:0] : index of the previous owner (lowest priority)
//   valid       : any request present
//   idx   [1:0] : first requester found searching last+1 .. last+4 (mod 4)
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               valid,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] hit;
    logic [SEL_W-1:0]   cand;
    logic               found;

    always_comb begin
        hit   = '0;
        cand  = '0;
        found = 1'b0;
        // Offsets 1..4 wrap naturally in SEL_W bits; offset 4 lands on last itself.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last + SEL_W'(k);
            if (!found && req[cand]) begin
                hit[cand] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign valid = |req;
    assign idx   = onehot_to_idx(hit);

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter / sequencer for a shared 4-to-1 mux (select pair plus
// active-high output disable). Select only moves while the output is disabled,
// and the disable is held for SETTLE_CYCLES after a select change before grant.
//   clk, rst_n : clock, async active-low reset
//   req   [3:0]: level requests, held until the requester is done
//   gnt   [3:0]: one-hot grant (registered)
//   sel   [1:0]: mux select (registered)
//   mux_dis    : 1 = mux output forced 0 (registered)
//   busy       : sequencer not in IDLE
//   timeout    : one-cycle pulse when a grant is revoked after MAX_HOLD cycles
// Optional: define MUX_ARB_TIMEOUT_EN to enable the MAX_HOLD revoke logic;
// otherwise timeout is tied 0 and MAX_HOLD is only range-checked.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned MAX_HOLD      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               mux_dis,
    output logic               busy,
    output logic               timeout
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
        $error("mux4_rr_arbiter: SETTLE_CYCLES or MAX_HOLD out of range");
    end

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;      // sel doubles as the current winner
    logic [SEL_W-1:0]   last_q, last_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               mux_dis_q, mux_dis_d;

    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
    logic       others_pending;

    assign others_pending = |(req & ~gnt_q);
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        mux_dis_d = mux_dis_q;
`ifdef MUX_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = SETTLE;
                    sel_d   = pick_idx;
                    cnt_d   = 4'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (!req[sel_q]) begin
                    // Abandoned before grant: owner history is not advanced.
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d   = GRANT;
                    gnt_d     = NUM_REQ'(1) << sel_q;
                    mux_dis_d = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_d    = 8'd0;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    mux_dis_d = 1'b1;
                    last_d    = sel_q;
`ifdef MUX_ARB_TIMEOUT_EN
                end else if (hold_q == HOLD_LAST && others_pending) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    mux_dis_d = 1'b1;
                    last_d    = sel_q;
                    timeout_d = 1'b1;
                end else if (hold_q != HOLD_LAST) begin
                    // Saturate so a late competitor revokes promptly.
                    hold_d = hold_q + 8'd1;
`endif
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            last_q    <= SEL_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            mux_dis_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            mux_dis_q <= mux_dis_d;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign mux_dis = mux_dis_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (SETTLE_CYCLES = 2, MAX_HOLD = 4).
// Build with MUX_ARB_TIMEOUT_EN defined to also exercise the hold timeout.
module tb_mux4_rr_arbiter;

    localparam int SETTLE = 2;
    localparam int MAXH   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       mux_dis, busy, timeout;

    int n_chk  = 0;
    int n_fail = 0;

    mux4_rr_arbiter #(.SETTLE_CYCLES(SETTLE), .MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .mux_dis (mux_dis),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants, sampled on the falling edge.
    logic [1:0] prev_sel = 2'd0;
    logic       prev_dis = 1'b1;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
            if (gnt != 4'd0) begin
                chk("inv_gnt_dis", {7'd0, mux_dis}, 8'd0);
                chk("inv_gnt_sel", {4'd0, gnt}, 8'd1 << sel);
            end
            if (sel != prev_sel) chk("inv_sel_chg", {7'd0, prev_dis}, 8'd1);
        end
        prev_sel = sel;
        prev_dis = mux_dis;
    end

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset with every requester asserted.
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        tick();
        chk("rst_gnt", gnt, 8'h0);
        chk("rst_sel", sel, 8'h0);
        chk("rst_dis", mux_dis, 8'h1);
        chk("rst_busy", busy, 8'h0);
        chk("rst_timeout", timeout, 8'h0);

        rst_n = 1'b1;
        tick();
        chk("first_sel", sel, 8'h0);
        chk("first_dis", mux_dis, 8'h1);
        chk("first_gnt0", gnt, 8'h0);
        chk("first_busy", busy, 8'h1);
        tick();
        chk("first_gnt1", gnt, 8'h0);
        chk("first_dis1", mux_dis, 8'h1);
        tick();
        chk("first_dis2", mux_dis, 8'h0);
        chk("first_timeout", timeout, 8'h0);

        // Rotation with all four held; owner re-requests right after release.
        for (int i = 0; i < 5; i++) begin
            chk("rr_gnt", gnt, 8'h1 << order[i]);
            chk("rr_sel", sel, 8'(order[i]));
            repeat (2) begin
                tick();
                chk("rr_hold", gnt, 8'h1 << order[i]);
            end
            req[order[i]] = 1'b0;
            tick();
            chk("rr_rel_gnt", gnt, 8'h0);
            chk("rr_rel_dis", mux_dis, 8'h1);
            if (i == 4) break;
            req[order[i]] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("rr_gap_gnt", gnt, 8'h0);
                chk("rr_gap_dis", mux_dis, 8'h1);
            end
            chk("rr_next_sel", sel, 8'(order[i+1]));
            tick();
        end
        req = 4'b0000;
        tick();
        tick();
        chk("idle_busy", busy, 8'h0);
        chk("idle_gnt", gnt, 8'h0);

        // Fresh reset, then req[2] abandons during SETTLE.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b0100;
        tick();
        chk("ab_sel", sel, 8'h2);
        chk("ab_busy", busy, 8'h1);
        chk("ab_dis", mux_dis, 8'h1);
        req = 4'b0000;
        tick();
        chk("ab_idle", busy, 8'h0);
        chk("ab_gnt", gnt, 8'h0);
        tick();
        tick();
        chk("ab_gnt_later", gnt, 8'h0);

        // last_owner still 3: req 1 wins over req 3.
        req = 4'b1010;
        tick();
        chk("ab_next_sel", sel, 8'h1);
        tick();
        tick();
        chk("g1_gnt", gnt, 8'h2);
        chk("g1_dis", mux_dis, 8'h0);

        // Asynchronous reset in the middle of requester 1's grant.
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", gnt, 8'h0);
        chk("arst_sel", sel, 8'h0);
        chk("arst_dis", mux_dis, 8'h1);
        chk("arst_busy", busy, 8'h0);
        tick();
        tick();
        req   = 4'b0000;
        rst_n = 1'b1;
        tick();

`ifdef MUX_ARB_TIMEOUT_EN
        req = 4'b1001;
        tick();
        chk("to_sel0", sel, 8'h0);
        tick();
        tick();
        chk("to_gnt0", gnt, 8'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("to_hold0", gnt, 8'h1);
            chk("to_nopulse", timeout, 8'h0);
        end
        tick();
        chk("to_revoke_gnt", gnt, 8'h0);
        chk("to_pulse", timeout, 8'h1);
        chk("to_revoke_dis", mux_dis, 8'h1);
        tick();
        chk("to_pulse_end", timeout, 8'h0);
        tick();
        chk("to_sel3", sel, 8'h3);
        tick();
        tick();
        chk("to_gnt3", gnt, 8'h8);
        req = 4'b0001;
        tick();
        chk("to_rel3", timeout, 8'h0);
        repeat (4) tick();
        chk("to_gnt0_again", gnt, 8'h1);
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("to_solo_gnt", gnt, 8'h1);
            chk("to_solo_timeout", timeout, 8'h0);
        end
        req = 4'b0000;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
